mem_wait_responder: RTL and testbench

//   Bus target for the processor memory port; it is the responder side of the Read/Write/Rdy handshake.

---
 rtl/mem_wait_responder_if.sv | 22 ++
 rtl/mem_wait_responder.sv | 116 +++++++++++
 tb/tb_mem_wait_responder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mem_wait_responder_if.sv
// Processor memory port bundle: Read/Write/Rdy handshake between
// a requester (master) and the wait-state memory target (slave).
interface mem_wait_responder_if;
    logic        iRead;
    logic        iWrite;
    logic [31:0] iAddr;
    logic [31:0] iData;
    logic [31:0] oData;
    logic        oRdy;
    logic        oErr;
    logic        oBusy;

    modport master (
        output iRead, iWrite, iAddr, iData,
        input  oData, oRdy, oErr, oBusy
    );

    modport slave (
        input  iRead, iWrite, iAddr, iData,
        output oData, oRdy, oErr, oBusy
    );
endinterface

// File: rtl/mem_wait_responder.sv
// Memory-port target: latches one request, serves it from a word RAM
// after WAIT_CYCLES wait states, then pulses oRdy (with oErr on bad requests).
module mem_wait_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input logic                  iClk,
    input logic                  iRst,
    mem_wait_responder_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                wr_q, wr_d;
    logic                err_q, err_d;
    logic [31:0]         rdata_q, rdata_d;

    logic [31:0]         mem_q [DEPTH];

    logic                req;
    logic                cap_err;
    logic [31:0]         ack_data;

    assign req = bus.iRead | bus.iWrite;

    // Upper address bits are range-checked rather than dropped
    assign cap_err = (|bus.iAddr[1:0])
                   | (|(bus.iAddr >> (ADDR_W + 2)))
                   | (bus.iRead & bus.iWrite);

    assign ack_data = err_q ? 32'h0 : mem_q[idx_q];

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'h0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // RAM is deliberately outside the reset domain
    always_ff @(posedge iClk) begin
        if (state_q == S_ACK && wr_q && !err_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        bus.oData = rdata_q;
        bus.oRdy  = 1'b0;
        bus.oErr  = 1'b0;
        bus.oBusy = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    bus.oBusy = 1'b1;
                    idx_d     = bus.iAddr[ADDR_W+1:2];
                    wdata_d   = bus.iData;
                    wr_d      = bus.iWrite;
                    err_d     = cap_err;
                    cnt_d     = 4'(WAIT_CYCLES);
                    state_d   = (WAIT_CYCLES > 0) ? S_WAIT : S_ACK;
                end
            end
            S_WAIT: begin
                bus.oBusy = 1'b1;
                cnt_d     = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                bus.oBusy = 1'b1;
                bus.oRdy  = 1'b1;
                bus.oErr  = err_q;
                state_d   = S_IDLE;
                if (!wr_q) begin
                    bus.oData = ack_data;
                    rdata_d   = ack_data;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_mem_wait_responder.sv
// Directed bench for mem_wait_responder: a vector table for single
// accesses plus hand sequences for back-to-back, early drop, zero-wait and reset.
module tb_mem_wait_responder;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_wait_responder_if b0 ();
    mem_wait_responder_if b1 ();

    mem_wait_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) u0 (
        .iClk(clk), .iRst(rst), .bus(b0)
    );
    mem_wait_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u1 (
        .iClk(clk), .iRst(rst), .bus(b1)
    );

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_err;
        logic        chk_data;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vec [14];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel) begin
            b1.iRead = rd; b1.iWrite = wr; b1.iAddr = a; b1.iData = d;
        end else begin
            b0.iRead = rd; b0.iWrite = wr; b0.iAddr = a; b0.iData = d;
        end
    endtask

    function automatic logic get_rdy(input bit sel);
        return sel ? b1.oRdy : b0.oRdy;
    endfunction

    // lat = negedges after the capture edge until oRdy is seen; -1 on timeout
    task automatic access(input bit sel, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input bit drop_early, output int lat,
                          output logic err, output logic [31:0] data);
        @(negedge clk);
        drive(sel, rd, wr, a, d);
        @(posedge clk);
        lat  = -1;
        err  = 1'b0;
        data = 32'h0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (drop_early) drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
            if (get_rdy(sel)) begin
                lat  = i;
                err  = sel ? b1.oErr : b0.oErr;
                data = sel ? b1.oData : b0.oData;
                break;
            end
        end
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          n;
        logic        err;
        logic [31:0] data;

        vec[0]  = '{1'b0, 1'b1, 32'h10,       32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        3};
        vec[1]  = '{1'b1, 1'b0, 32'h10,       32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 3};
        vec[2]  = '{1'b1, 1'b0, 32'h12,       32'h0,        1'b1, 1'b1, 32'h0,        3};
        vec[3]  = '{1'b1, 1'b0, 32'h10,       32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 3};
        vec[4]  = '{1'b0, 1'b1, 32'h0,        32'hA5A5A5A5, 1'b0, 1'b0, 32'h0,        3};
        vec[5]  = '{1'b0, 1'b1, 32'h400,      32'h12345678, 1'b1, 1'b0, 32'h0,        3};
        vec[6]  = '{1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 32'hA5A5A5A5, 3};
        vec[7]  = '{1'b0, 1'b1, 32'h20,       32'h11111111, 1'b0, 1'b0, 32'h0,        3};
        vec[8]  = '{1'b1, 1'b1, 32'h20,       32'h22222222, 1'b1, 1'b0, 32'h0,        3};
        vec[9]  = '{1'b1, 1'b0, 32'h20,       32'h0,        1'b0, 1'b1, 32'h11111111, 3};
        vec[10] = '{1'b0, 1'b1, 32'h3FC,      32'hCAFEF00D, 1'b0, 1'b0, 32'h0,        3};
        vec[11] = '{1'b1, 1'b0, 32'h3FC,      32'h0,        1'b0, 1'b1, 32'hCAFEF00D, 3};
        vec[12] = '{1'b1, 1'b0, 32'h80000000, 32'h0,        1'b1, 1'b1, 32'h0,        3};
        vec[13] = '{1'b0, 1'b1, 32'h11,       32'h99999999, 1'b1, 1'b0, 32'h0,        3};

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        chk("reset oRdy",  {31'h0, b0.oRdy},  32'h0);
        chk("reset oErr",  {31'h0, b0.oErr},  32'h0);
        chk("reset oBusy", {31'h0, b0.oBusy}, 32'h0);
        chk("reset oData", b0.oData,          32'h0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            access(1'b0, vec[i].rd, vec[i].wr, vec[i].addr, vec[i].data,
                   1'b0, lat, err, data);
            chk($sformatf("vec%0d lat", i), 32'(lat), 32'(vec[i].exp_lat));
            chk($sformatf("vec%0d err", i), {31'h0, err}, {31'h0, vec[i].exp_err});
            if (vec[i].chk_data)
                chk($sformatf("vec%0d data", i), data, vec[i].exp_data);
        end

        access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, lat, err, data);
        chk("post-misaligned-wr data", data, 32'hDEADBEEF);

        // Held read: second capture in the IDLE cycle after ACK
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        @(posedge clk);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (b0.oRdy) begin lat = i; break; end
        end
        chk("held first lat", 32'(lat), 32'd3);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) chk("held idle oBusy", {31'h0, b0.oBusy}, 32'h1);
            if (b0.oRdy) begin n = i; break; end
        end
        chk("held second gap", 32'(n), 32'd4);
        chk("held second data", b0.oData, 32'hDEADBEEF);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("held done oBusy", {31'h0, b0.oBusy}, 32'h0);

        // Write dropped during WAIT still commits
        access(1'b0, 1'b0, 1'b1, 32'h30, 32'h0BADF00D, 1'b1, lat, err, data);
        chk("drop lat", 32'(lat), 32'd3);
        chk("drop err", {31'h0, err}, 32'h0);
        access(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, lat, err, data);
        chk("drop readback", data, 32'h0BADF00D);

        // Zero wait states
        access(1'b1, 1'b0, 1'b1, 32'h40, 32'h55AA55AA, 1'b0, lat, err, data);
        chk("w0 write lat", 32'(lat), 32'd1);
        access(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, lat, err, data);
        chk("w0 read lat", 32'(lat), 32'd1);
        chk("w0 read data", data, 32'h55AA55AA);
        access(1'b1, 1'b1, 1'b0, 32'h42, 32'h0, 1'b0, lat, err, data);
        chk("w0 misaligned err", {31'h0, err}, 32'h1);

        // Reset in WAIT of a write abandons it
        access(1'b0, 1'b0, 1'b1, 32'h50, 32'h77777777, 1'b0, lat, err, data);
        access(1'b0, 1'b1, 1'b0, 32'h50, 32'h0, 1'b0, lat, err, data);
        chk("pre-reset data", data, 32'h77777777);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 32'h50, 32'h88888888);
        @(posedge clk);
        @(negedge clk);
        chk("mid oBusy", {31'h0, b0.oBusy}, 32'h1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        #1;
        chk("rst oRdy",  {31'h0, b0.oRdy},  32'h0);
        chk("rst oErr",  {31'h0, b0.oErr},  32'h0);
        chk("rst oBusy", {31'h0, b0.oBusy}, 32'h0);
        chk("rst oData", b0.oData,          32'h0);
        @(negedge clk);
        rst = 1'b0;
        access(1'b0, 1'b1, 1'b0, 32'h50, 32'h0, 1'b0, lat, err, data);
        chk("post-rst lat", 32'(lat), 32'd3);
        chk("post-rst data", data, 32'h77777777);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
